mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port, variable-latency memory between the instruction-fetch port and the load/store (data) port of the RV32 core. Accepts one request at a time through a req/gnt handshake, holds the granted access on the memory port until the memory signals completion, then returns data and a completion pulse to the owner. A wait-cycle watchdog aborts accesses the memory never completes.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    // Legal watchdog limits are 1..255 busy cycles.
    function automatic bit max_wait_ok(input int unsigned max_wait);
        return (max_wait >= 1) && (max_wait <= 255);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker: one-hot grant, conflicts go to the port not granted last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req_i,
    input  logic       dm_req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (if_req_i && dm_req_i) begin
            if (last_i == PORT_DM) begin
                gnt_o[PORT_IF] = 1'b1;
            end else begin
                gnt_o[PORT_DM] = 1'b1;
            end
        end else if (dm_req_i) begin
            gnt_o[PORT_DM] = 1'b1;
        end else if (if_req_i) begin
            gnt_o[PORT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports, with a busy watchdog.
// Define MEM_ARB_RR_EN for round-robin conflict resolution; otherwise the data port always wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned       CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(MAX_WAIT - 1);

    if (!max_wait_ok(MAX_WAIT)) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be in 1..255");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        pick_gnt;
    logic              pick_last;
    logic              done;
    logic              timeout;

`ifdef MEM_ARB_RR_EN
    logic last_q;

    // Remembers the most recently granted port; updated only on a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= PORT_IF;
        end else if (if_gnt || dm_gnt) begin
            last_q <= dm_gnt ? PORT_DM : PORT_IF;
        end
    end

    assign pick_last = last_q;
`else
    assign pick_last = PORT_IF;
`endif

    // Requests are masked while reset is held so no grant leaks out of reset.
    mem_arb_pick u_pick (
        .if_req_i (if_req & ~reset),
        .dm_req_i (dm_req & ~reset),
        .last_i   (pick_last),
        .gnt_o    (pick_gnt)
    );

    assign timeout = !mem_ready && (cnt_q == LIMIT);
    assign done    = mem_ready || (cnt_q == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        dm_rvalid   = 1'b0;
        if_rdata    = '0;
        dm_rdata    = '0;
        err         = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_gnt[PORT_DM]) begin
                    dm_gnt      = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    cnt_d       = '0;
                    state_d     = BUSY_DM;
                end else if (pick_gnt[PORT_IF]) begin
                    if_gnt      = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    cnt_d       = '0;
                    state_d     = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (done) begin
                    if_rvalid = 1'b1;
                    err       = timeout;
                    if_rdata  = mem_ready ? mem_rdata : '0;
                    mem_en_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BUSY_DM: begin
                if (done) begin
                    dm_rvalid = 1'b1;
                    err       = timeout;
                    dm_rdata  = (mem_ready && !mem_we_q) ? mem_rdata : '0;
                    mem_en_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; honours MEM_ARB_RR_EN for conflict expectations.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One access from a single port; ready_at=0 means the memory never answers.
    task automatic access(input bit is_dm, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ready_at, input logic [31:0] rdata);
        bit tmo;
        int last;
        tmo  = (ready_at == 0) || (ready_at > int'(MAX_WAIT));
        last = tmo ? int'(MAX_WAIT) : ready_at;
        tick();
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(negedge clk);
        check_eq("if_gnt", 32'(if_gnt), 32'(!is_dm));
        check_eq("dm_gnt", 32'(dm_gnt), 32'(is_dm));
        check_eq("mem_en_at_gnt", 32'(mem_en), 32'd0);
        for (int k = 1; k <= last; k++) begin
            tick();
            if_req    = 1'b0;
            dm_req    = 1'b0;
            mem_ready = (k == ready_at);
            mem_rdata = rdata;
            @(negedge clk);
            check_eq("mem_en", 32'(mem_en), 32'd1);
            check_eq("mem_addr", mem_addr, addr);
            check_eq("mem_we", 32'(mem_we), 32'(is_dm && we));
            if (is_dm && we) check_eq("mem_wdata", mem_wdata, wdata);
            check_eq("busy_gnt", 32'({if_gnt, dm_gnt}), 32'd0);
            check_eq(is_dm ? "dm_rvalid" : "if_rvalid", 32'(is_dm ? dm_rvalid : if_rvalid),
                     32'(k == last));
            check_eq(is_dm ? "if_rvalid_idle" : "dm_rvalid_idle",
                     32'(is_dm ? if_rvalid : dm_rvalid), 32'd0);
            check_eq("err", 32'(err), 32'(k == last && tmo));
            check_eq(is_dm ? "dm_rdata" : "if_rdata", is_dm ? dm_rdata : if_rdata,
                     (k == last && !tmo && !(is_dm && we)) ? rdata : 32'd0);
            check_eq(is_dm ? "if_rdata_idle" : "dm_rdata_idle", is_dm ? if_rdata : dm_rdata, 32'd0);
        end
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("mem_en_after", 32'(mem_en), 32'd0);
        check_eq("rvalid_after", 32'({if_rvalid, dm_rvalid}), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        tick();
        @(negedge clk);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_outs", 32'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, err}), 32'd0);
        reset = 1'b0;

        // Lone fetch, zero-wait; then store with 3 waits, load with 1 wait.
        access(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h0050_0093);
        access(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4, 32'h1234_5678);
        access(1'b1, 1'b0, 32'h0000_2004, 32'h0, 2, 32'hCAFE_F00D);

        // Watchdog abort, then ready exactly at the limit.
        access(1'b0, 1'b0, 32'h0000_0200, 32'h0, 0, 32'hFFFF_FFFF);
        access(1'b1, 1'b0, 32'h0000_3000, 32'h0, int'(MAX_WAIT), 32'hA5A5_5A5A);

        // Both ports requesting continuously, zero-wait memory.
        do_reset();
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0400;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_4000;
        for (int s = 0; s < 4; s++) begin
            bit exp_dm;
`ifdef MEM_ARB_RR_EN
            exp_dm = (s % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            @(negedge clk);
            check_eq("conf_dm_gnt", 32'(dm_gnt), 32'(exp_dm));
            check_eq("conf_if_gnt", 32'(if_gnt), 32'(!exp_dm));
            tick();
            mem_ready = 1'b1;
            mem_rdata = 32'h1000 + 32'(s);
            @(negedge clk);
            check_eq("conf_addr", mem_addr, exp_dm ? 32'h0000_4000 : 32'h0000_0400);
            check_eq("conf_dm_rvalid", 32'(dm_rvalid), 32'(exp_dm));
            check_eq("conf_if_rvalid", 32'(if_rvalid), 32'(!exp_dm));
            tick();
            mem_ready = 1'b0;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of a busy fetch; the held request is re-granted.
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0300;
        @(negedge clk);
        check_eq("mid_gnt", 32'(if_gnt), 32'd1);
        tick();
        @(negedge clk);
        check_eq("mid_busy_en", 32'(mem_en), 32'd1);
        tick();
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        #1;
        check_eq("mid_rst_en", 32'(mem_en), 32'd0);
        check_eq("mid_rst_rvalid", 32'({if_rvalid, dm_rvalid, err}), 32'd0);
        check_eq("mid_rst_gnt", 32'({if_gnt, dm_gnt}), 32'd0);
        tick();
        reset     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("regrant", 32'(if_gnt), 32'd1);
        tick();
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0013;
        @(negedge clk);
        check_eq("regrant_addr", mem_addr, 32'h0000_0300);
        check_eq("regrant_rvalid", 32'(if_rvalid), 32'd1);
        check_eq("regrant_rdata", if_rdata, 32'h0000_0013);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("final_idle_en", 32'(mem_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
